// File: rtl/pipeline_pkg.sv
// Shared constants for the MIPS pipeline hazard sequencer.
// FSM state encodings, the zero register and the control bundle type.
package pipeline_pkg;

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH      = 2'd2;
  localparam logic [1:0] ST_MEM_WAIT   = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector between the EX load and the ID reader.
// Ports: id_rs/id_rt/id_uses_rt (ID), ex_mem_read/ex_rt (EX), hz out.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [1:0] ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       hz
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = id_uses_rt && (ex_rt == id_rt);
  assign hz = (ex_mem_read != 2'd0) && (ex_rt != REG_ZERO)
            && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the IF/ID, ID/EX, EX/MEM buffers.
// Ports: hazard inputs from ID/EX/MEM, per-buffer enables, state, stall count.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic        i_id_uses_rt,
  input  logic [1:0]  i_ex_memRead,
  input  logic [4:0]  i_ex_rt,
  input  logic        i_ex_branch_taken,
  input  logic        i_ex_jump,
  input  logic        i_mem_busy,
  output logic        o_pc_write,
  output logic        o_if_id_write,
  output logic        o_if_id_flush,
  output logic        o_id_ex_write,
  output logic        o_id_ex_bubble,
  output logic        o_ex_mem_write,
  output logic [1:0]  o_state,
  output logic [15:0] o_stall_cycles
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  logic [1:0] state, state_n;
  logic [1:0] ret, ret_n;
  logic [1:0] cnt, cnt_n;
  logic [1:0] eff;
  logic       hz, rd;
  logic       frz, fl, rdr, stl;
  ctrl_t      ctl;

  load_use_detect u_lud (
    .id_rs       (i_id_rs),
    .id_rt       (i_id_rt),
    .id_uses_rt  (i_id_uses_rt),
    .ex_mem_read (i_ex_memRead),
    .ex_rt       (i_ex_rt),
    .hz          (hz)
  );

  assign rd = i_ex_branch_taken | i_ex_jump;

  // On the release cycle MEM_WAIT decodes as the saved return state.
  assign eff = (state == ST_MEM_WAIT) ? ret : state;

  // Mutually exclusive actions in priority order.
  assign frz = i_mem_busy;
  assign fl  = !frz && (eff == ST_FLUSH);
  assign rdr = !frz && !fl && rd;
  assign stl = !frz && !fl && !rd && hz && (eff == ST_RUN);

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state <= ST_RUN;
      ret   <= ST_RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      ret   <= ret_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = ST_RUN;
    ret_n   = ret;
    cnt_n   = cnt;
    unique case (1'b1)
      frz: begin
        state_n = ST_MEM_WAIT;
        if (state != ST_MEM_WAIT)
          ret_n = (state == ST_FLUSH) ? ST_FLUSH : ST_RUN;
      end
      fl: begin
        cnt_n   = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        state_n = (cnt <= 2'd1) ? ST_RUN : ST_FLUSH;
      end
      rdr: begin
        if (FLUSH_CYCLES > 1) begin
          cnt_n   = FLUSH_LOAD;
          state_n = ST_FLUSH;
        end
      end
      stl: state_n = ST_LOAD_STALL;
      default: state_n = ST_RUN;
    endcase
  end

  always_comb begin
    ctl = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
            id_ex_write: 1'b1, id_ex_bubble: 1'b0, ex_mem_write: 1'b1};
    if (!i_rst_n) begin
      ctl = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
              id_ex_write: 1'b0, id_ex_bubble: 1'b1, ex_mem_write: 1'b0};
    end else begin
      unique case (1'b1)
        frz: ctl = '0;
        fl, rdr: begin
          ctl.if_id_flush  = 1'b1;
          ctl.id_ex_bubble = 1'b1;
        end
        stl: begin
          ctl.pc_write     = 1'b0;
          ctl.if_id_write  = 1'b0;
          ctl.id_ex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_pc_write     = ctl.pc_write;
  assign o_if_id_write  = ctl.if_id_write;
  assign o_if_id_flush  = ctl.if_id_flush;
  assign o_id_ex_write  = ctl.id_ex_write;
  assign o_id_ex_bubble = ctl.id_ex_bubble;
  assign o_ex_mem_write = ctl.ex_mem_write;
  assign o_state        = state;

  always_ff @(posedge clk) begin
    if (!i_rst_n)
      o_stall_cycles <= 16'd0;
    else if (!ctl.pc_write && (o_stall_cycles != 16'hFFFF))
      o_stall_cycles <= o_stall_cycles + 16'd1;
  end

endmodule
